dmem_responder: RTL and testbench

Data-memory responder for the pipelined RV64 core. It sits on the far end of the core's data-memory port, sampling the core's `addr`, `wr_en`, `wdata` and `wmask` outputs and returning `rdata` to it. It owns a 64-bit-wide, byte-addressable RAM and handles sub-word store/load lane alignment, misalignment and range errors, and a configurable wait-state latency behind a valid/ready handshake.

---
 rtl/dmem_responder_pkg.sv | 29 ++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder_lane_align.sv | 28 ++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic mask_legal(input logic [7:0] m);
        return (m == MASK_B) || (m == MASK_H) || (m == MASK_W) || (m == MASK_D);
    endfunction

    // Widen a per-byte enable into a per-bit mask.
    function automatic logic [63:0] byte_expand(input logic [7:0] m);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data-memory port: request handshake, store payload and response.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        wr_en;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic        rsp_valid;
    logic        err;

    modport master (
        output req_valid, addr, wr_en, wdata, wmask,
        input  req_ready, rdata, rsp_valid, err
    );

    modport slave (
        input  req_valid, addr, wr_en, wdata, wmask,
        output req_ready, rdata, rsp_valid, err
    );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering between a right-justified datum and a 64-bit RAM word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  off_i,
    input  logic [7:0]  wmask_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rword_i,
    output logic [7:0]  lane_mask_o,
    output logic [63:0] lane_data_o,
    output logic [63:0] rd_data_o,
    output logic        misalign_o
);

    logic [15:0] wide_mask;
    logic [63:0] rshift;

    always_comb begin
        // Any enable shifted past byte 7 means the access spans two words.
        wide_mask   = {8'b0, wmask_i} << off_i;
        lane_mask_o = wide_mask[7:0];
        misalign_o  = |wide_mask[15:8];
        lane_data_o = wdata_i << {off_i, 3'b000};
        rshift      = rword_i >> {off_i, 3'b000};
        rd_data_o   = rshift & byte_expand(wmask_i);
    end

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressable 64-bit data RAM behind a valid/ready port with optional wait states.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic             clk,
    input logic             nrst,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned ADDR_BITS = IDX_W + 3;
    localparam bit          HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] addr_q;
    logic        wr_en_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;

    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem [DEPTH_WORDS];

    logic              accept;
    logic              commit;
    logic [31:0]       c_addr;
    logic              c_wr_en;
    logic [63:0]       c_wdata;
    logic [7:0]        c_wmask;
    logic [IDX_W-1:0]  c_idx;
    logic              c_oor;
    logic              c_err;
    logic [63:0]       rword;
    logic [7:0]        lane_mask;
    logic [63:0]       lane_data;
    logic [63:0]       rd_data;
    logic              misalign;

    assign bus.req_ready = nrst && (state_q != WAIT);
    assign bus.rsp_valid = nrst && (state_q == RESP);
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;

    assign accept = bus.req_valid && bus.req_ready;

    // Zero wait states commit on the accept edge from the live bus; otherwise
    // the captured request commits as the countdown expires.
    always_comb begin
        commit = 1'b0;
        if (nrst) begin
            if (HAS_WAIT) begin
                commit = (state_q == WAIT) && (cnt_q == 4'd0);
            end else begin
                commit = accept;
            end
        end
    end

    always_comb begin
        c_addr  = HAS_WAIT ? addr_q  : bus.addr;
        c_wr_en = HAS_WAIT ? wr_en_q : bus.wr_en;
        c_wdata = HAS_WAIT ? wdata_q : bus.wdata;
        c_wmask = HAS_WAIT ? wmask_q : bus.wmask;
    end

    assign c_idx = c_addr[3 +: IDX_W];
    assign c_oor = (c_addr >> ADDR_BITS) != '0;
    assign rword = mem[c_idx];

    dmem_lane_align u_align (
        .off_i       (c_addr[2:0]),
        .wmask_i     (c_wmask),
        .wdata_i     (c_wdata),
        .rword_i     (rword),
        .lane_mask_o (lane_mask),
        .lane_data_o (lane_data),
        .rd_data_o   (rd_data),
        .misalign_o  (misalign)
    );

    always_comb begin
        c_err   = c_oor || misalign || !mask_legal(c_wmask);
        err_d   = c_err;
        rdata_d = (c_wr_en || c_err) ? '0 : rd_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d = HAS_WAIT ? WAIT : RESP;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.addr;
            wr_en_q <= bus.wr_en;
            wdata_q <= bus.wdata;
            wmask_q <= bus.wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_wr_en && !c_err) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (lane_mask[i]) begin
                    mem[c_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed checks of dmem_responder with zero, two and three wait states.
module tb_dmem_responder;

    logic clk;
    logic rst_n;
    logic rst2_n;
    int   checks;
    int   errors;

    dmem_responder_if b0 ();
    dmem_responder_if b3 ();
    dmem_responder_if b2 ();

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .nrst(rst_n),  .bus(b0));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .nrst(rst_n),  .bus(b3));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .nrst(rst2_n), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic v, input logic we, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] m);
        b0.req_valid = v; b0.wr_en = we; b0.addr = a; b0.wdata = d; b0.wmask = m;
    endtask

    task automatic drv3(input logic v, input logic we, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] m);
        b3.req_valid = v; b3.wr_en = we; b3.addr = a; b3.wdata = d; b3.wmask = m;
    endtask

    task automatic drv2(input logic v, input logic we, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] m);
        b2.req_valid = v; b2.wr_en = we; b2.addr = a; b2.wdata = d; b2.wmask = m;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        drv0(1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        drv3(1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        drv2(1'b0, 1'b0, 32'h0, 64'h0, 8'h0);

        step(); step();
        chk("rst_ready",  b0.req_ready, 1'b0);
        chk("rst_rsp",    b0.rsp_valid, 1'b0);
        chk("rst_err",    b0.err,       1'b0);
        chk("rst_rdata",  b0.rdata,     64'h0);
        chk("rst_ready3", b3.req_ready, 1'b0);

        rst_n  = 1'b1;
        rst2_n = 1'b1;
        step();
        chk("post_rst_rsp",   b0.rsp_valid, 1'b0);
        chk("post_rst_ready", b0.req_ready, 1'b1);

        // zero wait states: back-to-back SD then LD
        drv0(1'b1, 1'b1, 32'h10, 64'h1122334455667788, 8'hFF); step();
        chk("sd_rsp",   b0.rsp_valid, 1'b1);
        chk("sd_err",   b0.err,       1'b0);
        chk("sd_rdata", b0.rdata,     64'h0);
        drv0(1'b1, 1'b0, 32'h10, 64'h0, 8'hFF); step();
        chk("ld_rsp",   b0.rsp_valid, 1'b1);
        chk("ld_err",   b0.err,       1'b0);
        chk("ld_rdata", b0.rdata,     64'h1122334455667788);

        drv0(1'b1, 1'b1, 32'h14, 64'hDEADBEEF, 8'h0F); step();
        chk("sw_rsp", b0.rsp_valid, 1'b1);
        chk("sw_err", b0.err,       1'b0);
        drv0(1'b1, 1'b0, 32'h10, 64'h0, 8'hFF); step();
        chk("ld_after_sw", b0.rdata, 64'hDEADBEEF55667788);
        drv0(1'b1, 1'b0, 32'h14, 64'h0, 8'h0F); step();
        chk("lw_14", b0.rdata, 64'h00000000DEADBEEF);
        drv0(1'b1, 1'b0, 32'h13, 64'h0, 8'h01); step();
        chk("lb_13", b0.rdata, 64'h55);
        drv0(1'b1, 1'b0, 32'h16, 64'h0, 8'h03); step();
        chk("lh_16", b0.rdata, 64'hDEAD);

        drv0(1'b1, 1'b1, 32'h16, 64'hCAFEBABE, 8'h0F); step();
        chk("mis_rsp",   b0.rsp_valid, 1'b1);
        chk("mis_err",   b0.err,       1'b1);
        chk("mis_rdata", b0.rdata,     64'h0);
        drv0(1'b1, 1'b0, 32'h10, 64'h0, 8'hFF); step();
        chk("after_mis_err",   b0.err,   1'b0);
        chk("after_mis_rdata", b0.rdata, 64'hDEADBEEF55667788);

        drv0(1'b1, 1'b0, 32'h2000, 64'h0, 8'hFF); step();
        chk("oor_err",   b0.err,   1'b1);
        chk("oor_rdata", b0.rdata, 64'h0);
        drv0(1'b1, 1'b0, 32'h10, 64'h0, 8'h07); step();
        chk("illmask_err",   b0.err,   1'b1);
        chk("illmask_rdata", b0.rdata, 64'h0);
        drv0(1'b1, 1'b0, 32'h17, 64'h0, 8'h01); step();
        chk("lb_17_err",   b0.err,   1'b0);
        chk("lb_17_rdata", b0.rdata, 64'hDE);
        drv0(1'b1, 1'b0, 32'h15, 64'h0, 8'h0F); step();
        chk("lw_mis_err",   b0.err,   1'b1);
        chk("lw_mis_rdata", b0.rdata, 64'h0);
        drv0(1'b0, 1'b0, 32'h0, 64'h0, 8'h0); step();
        chk("idle_rsp",   b0.rsp_valid, 1'b0);
        chk("hold_err",   b0.err,       1'b1);
        chk("hold_rdata", b0.rdata,     64'h0);

        // three wait states; a request held during WAIT must be ignored
        drv3(1'b1, 1'b1, 32'h8, 64'h0123456789ABCDEF, 8'hFF); step();
        chk("w3_ready_1", b3.req_ready, 1'b0);
        chk("w3_rsp_1",   b3.rsp_valid, 1'b0);
        drv3(1'b1, 1'b1, 32'h8, 64'hFFFFFFFFFFFFFFFF, 8'hFF); step();
        chk("w3_ready_2", b3.req_ready, 1'b0);
        chk("w3_rsp_2",   b3.rsp_valid, 1'b0);
        step();
        chk("w3_ready_3", b3.req_ready, 1'b0);
        chk("w3_rsp_3",   b3.rsp_valid, 1'b0);
        step();
        chk("w3_rsp_4",   b3.rsp_valid, 1'b1);
        chk("w3_ready_4", b3.req_ready, 1'b1);
        chk("w3_err_4",   b3.err,       1'b0);
        drv3(1'b1, 1'b0, 32'h8, 64'h0, 8'hFF); step();
        chk("w3_ld_ready", b3.req_ready, 1'b0);
        chk("w3_ld_rsp1",  b3.rsp_valid, 1'b0);
        drv3(1'b0, 1'b0, 32'h0, 64'h0, 8'h0); step(); step();
        chk("w3_ld_rsp3", b3.rsp_valid, 1'b0);
        step();
        chk("w3_ld_rsp4", b3.rsp_valid, 1'b1);
        chk("w3_ld_data", b3.rdata,     64'h0123456789ABCDEF);
        step();
        chk("w3_idle_rsp",   b3.rsp_valid, 1'b0);
        chk("w3_hold_rdata", b3.rdata,     64'h0123456789ABCDEF);

        // two wait states, reset abandons an in-flight store
        drv2(1'b1, 1'b1, 32'h20, 64'h55, 8'h01); step();
        drv2(1'b0, 1'b0, 32'h0, 64'h0, 8'h0); step();
        chk("w2_pre_rsp1", b2.rsp_valid, 1'b0);
        step();
        chk("w2_pre_rsp2", b2.rsp_valid, 1'b1);
        step();
        drv2(1'b1, 1'b1, 32'h20, 64'hAA, 8'h01); step();
        chk("w2_wait_ready", b2.req_ready, 1'b0);
        drv2(1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
        rst2_n = 1'b0;
        step();
        chk("w2_rst_rsp", b2.rsp_valid, 1'b0);
        rst2_n = 1'b1;
        step();
        chk("w2_after_rsp1", b2.rsp_valid, 1'b0);
        step();
        chk("w2_after_rsp2", b2.rsp_valid, 1'b0);
        chk("w2_after_err",  b2.err,       1'b0);
        drv2(1'b1, 1'b0, 32'h20, 64'h0, 8'h01); step();
        drv2(1'b0, 1'b0, 32'h0, 64'h0, 8'h0); step(); step();
        chk("w2_lb_rsp",   b2.rsp_valid, 1'b1);
        chk("w2_lb_err",   b2.err,       1'b0);
        chk("w2_lb_rdata", b2.rdata,     64'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
